// File: rtl/lcd_pkg.sv
// Shared constants for the ST7735-class panel controller: command codes, colours,
// FSM encoding and the power-up init ROM.
package lcd_pkg;

   localparam logic [7:0] CMD_SLPOUT = 8'h11;
   localparam logic [7:0] CMD_DISPON = 8'h29;
   localparam logic [7:0] CMD_CASET  = 8'h2A;
   localparam logic [7:0] CMD_RASET  = 8'h2B;
   localparam logic [7:0] CMD_RAMWR  = 8'h2C;
   localparam logic [7:0] CMD_MADCTL = 8'h36;
   localparam logic [7:0] CMD_COLMOD = 8'h3A;

   localparam logic [15:0] COL_BLACK = 16'h0000;
   localparam logic [15:0] COL_WHITE = 16'hFFFF;
   localparam logic [15:0] COL_RED   = 16'hF800;
   localparam logic [15:0] COL_GREEN = 16'h07E0;
   localparam logic [15:0] COL_BLUE  = 16'h001F;

   localparam logic [2:0] ST_RST_LOW  = 3'd0;
   localparam logic [2:0] ST_RST_WAIT = 3'd1;
   localparam logic [2:0] ST_INIT     = 3'd2;
   localparam logic [2:0] ST_IDLE     = 3'd3;
   localparam logic [2:0] ST_WIN      = 3'd4;
   localparam logic [2:0] ST_STREAM   = 3'd5;

   // Which half of the current pixel the shifter is working on.
   typedef enum logic [1:0] {
      PIX_NONE = 2'd0,
      PIX_HI   = 2'd1,
      PIX_LO   = 2'd2
   } pix_stage_t;

   typedef enum logic [1:0] {
      PH_SETUP = 2'd0,
      PH_LOW   = 2'd1,
      PH_HIGH  = 2'd2,
      PH_TAIL  = 2'd3
   } spi_phase_t;

   localparam int INIT_DEPTH = 6;
   localparam int WIN_DEPTH  = 11;

   // Entry format is {dc, byte}; entry 0 must stay SLPOUT, the controller waits after it.
   function automatic logic [8:0] init_rom(input logic [3:0] idx);
      logic [8:0] entry;
      case (idx)
         4'd0:    entry = {1'b0, CMD_SLPOUT};
         4'd1:    entry = {1'b0, CMD_MADCTL};
         4'd2:    entry = {1'b1, 8'h00};
         4'd3:    entry = {1'b0, CMD_COLMOD};
         4'd4:    entry = {1'b1, 8'h05};
         4'd5:    entry = {1'b0, CMD_DISPON};
         default: entry = 9'h000;
      endcase
      return entry;
   endfunction

endpackage

// File: rtl/spi_byte_tx.sv
// Mode-0, MSB-first byte shifter: one setup cycle, eight SCL periods of 2*CLK_DIV
// cycles, one trailing low cycle, then a one-cycle tx_done.
module spi_byte_tx
   import lcd_pkg::*;
#(
   parameter int CLK_DIV = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       dc,
   input  logic [7:0] data,
   output logic       busy,
   output logic       tx_done,
   output logic       scl,
   output logic       sda,
   output logic       dc_line
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   spi_phase_t      phase;
   logic [DW-1:0]   div_cnt;
   logic [2:0]      bit_cnt;
   logic [7:0]      shreg;
   logic            div_end;

   assign div_end = (div_cnt == DW'(CLK_DIV - 1));

   // NOTE: all state below uses non-blocking assignments so every register samples
   // pre-edge values; blocking here would make the shift order depend on statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy    <= 1'b0;
         tx_done <= 1'b0;
         phase   <= PH_SETUP;
         div_cnt <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         scl     <= 1'b0;
         sda     <= 1'b0;
         dc_line <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         if (!busy) begin
            if (start) begin
               busy    <= 1'b1;
               phase   <= PH_SETUP;
               dc_line <= dc;
               shreg   <= data;
               sda     <= data[7];
            end
         end else begin
            case (phase)
               PH_SETUP: begin
                  phase   <= PH_LOW;
                  div_cnt <= '0;
                  bit_cnt <= 3'd7;
               end
               PH_LOW: begin
                  if (div_end) begin
                     scl     <= 1'b1;
                     phase   <= PH_HIGH;
                     div_cnt <= '0;
                  end else begin
                     div_cnt <= div_cnt + 1'b1;
                  end
               end
               PH_HIGH: begin
                  if (div_end) begin
                     // SDA only moves together with the falling SCL edge.
                     scl     <= 1'b0;
                     div_cnt <= '0;
                     if (bit_cnt == 3'd0) begin
                        phase <= PH_TAIL;
                     end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                        shreg   <= {shreg[6:0], 1'b0};
                        sda     <= shreg[6];
                        phase   <= PH_LOW;
                     end
                  end else begin
                     div_cnt <= div_cnt + 1'b1;
                  end
               end
               PH_TAIL: begin
                  busy    <= 1'b0;
                  tx_done <= 1'b1;
               end
               default: phase <= PH_SETUP;
            endcase
         end
      end
   end

endmodule

// File: rtl/lcd_spi_ctrl.sv
// ST7735-class panel controller: reset/init sequencing, window setup and flow-controlled
// RGB565 streaming over a single spi_byte_tx shifter.
module lcd_spi_ctrl
   import lcd_pkg::*;
#(
   parameter int LCD_W         = 132,
   parameter int LCD_H         = 162,
   parameter int CLK_DIV       = 2,
   parameter int RST_CYCLES    = 3000,
   parameter int SLPOUT_CYCLES = 50000,
   parameter int X_OFS         = 0,
   parameter int Y_OFS         = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        win_valid,
   output logic        win_ready,
   input  logic [7:0]  win_x0,
   input  logic [7:0]  win_y0,
   input  logic [7:0]  win_x1,
   input  logic [7:0]  win_y1,
   output logic        win_err,
   input  logic        pix_valid,
   output logic        pix_ready,
   input  logic [15:0] pix_data,
   output logic        frame_done,
   output logic        init_done,
   output logic        busy,
   input  logic        bl_en,
   output logic        lcd_rst_n_out,
   output logic        lcd_bl_out,
   output logic        lcd_cs_n_out,
   output logic        lcd_dc_out,
   output logic        lcd_clk_out,
   output logic        lcd_data_out
);

   localparam logic [31:0] RST_LAST = 32'(RST_CYCLES - 1);
   localparam logic [31:0] SLP_LAST = 32'(SLPOUT_CYCLES - 1);
   localparam logic [7:0]  X_OFS8   = 8'(X_OFS);
   localparam logic [7:0]  Y_OFS8   = 8'(Y_OFS);

   logic [2:0]  state;
   logic [31:0] wait_cnt;
   logic [3:0]  idx;
   logic        pending;
   logic        slp_wait;
   pix_stage_t  pix_stage;
   logic [15:0] pix_cnt;
   logic [7:0]  pix_lo;
   logic [7:0]  x0_q, y0_q, x1_q, y1_q;
   logic        win_err_q, frame_done_q, init_done_q;
   logic        cs_n_q, rst_out_q, frame_seen;

   logic        tx_start, tx_dc, tx_busy, tx_done;
   logic [7:0]  tx_data;
   logic [8:0]  win_entry;
   logic        win_bad;
   logic        pix_fire;
   logic [15:0] win_pixels;

   assign win_ready     = (state == ST_IDLE);
   assign busy          = (state != ST_IDLE);
   assign pix_ready     = (state == ST_STREAM) && !pending && !tx_busy &&
                          (pix_stage == PIX_NONE) && (pix_cnt != 16'd0);
   assign pix_fire      = pix_valid && pix_ready;
   assign win_err       = win_err_q;
   assign frame_done    = frame_done_q;
   assign init_done     = init_done_q;
   assign lcd_cs_n_out  = cs_n_q;
   assign lcd_rst_n_out = rst_out_q;
   assign lcd_bl_out    = bl_en && frame_seen;

   assign win_bad = (win_x0 > win_x1) || (win_y0 > win_y1) ||
                    (32'(win_x1) >= 32'(LCD_W)) || (32'(win_y1) >= 32'(LCD_H));

   // Corners are already range-checked, so the product fits 16 bits (max 255*255).
   assign win_pixels = (16'(win_x1) - 16'(win_x0) + 16'd1) *
                       (16'(win_y1) - 16'(win_y0) + 16'd1);

   always_comb begin
      win_entry = 9'h000;
      case (idx)
         4'd0:    win_entry = {1'b0, CMD_CASET};
         4'd1:    win_entry = {1'b1, 8'h00};
         4'd2:    win_entry = {1'b1, x0_q + X_OFS8};
         4'd3:    win_entry = {1'b1, 8'h00};
         4'd4:    win_entry = {1'b1, x1_q + X_OFS8};
         4'd5:    win_entry = {1'b0, CMD_RASET};
         4'd6:    win_entry = {1'b1, 8'h00};
         4'd7:    win_entry = {1'b1, y0_q + Y_OFS8};
         4'd8:    win_entry = {1'b1, 8'h00};
         4'd9:    win_entry = {1'b1, y1_q + Y_OFS8};
         4'd10:   win_entry = {1'b0, CMD_RAMWR};
         default: win_entry = 9'h000;
      endcase
   end

   // NOTE: every output of this block is given a default first, so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      tx_start = 1'b0;
      tx_dc    = 1'b0;
      tx_data  = 8'h00;
      case (state)
         ST_INIT: begin
            if (!pending && !slp_wait) begin
               tx_start          = 1'b1;
               {tx_dc, tx_data}  = init_rom(idx);
            end
         end
         ST_WIN: begin
            if (!pending) begin
               tx_start          = 1'b1;
               {tx_dc, tx_data}  = win_entry;
            end
         end
         ST_STREAM: begin
            if (pix_fire) begin
               tx_start = 1'b1;
               tx_dc    = 1'b1;
               tx_data  = pix_data[15:8];
            end else if (pix_stage == PIX_LO && !pending) begin
               tx_start = 1'b1;
               tx_dc    = 1'b1;
               tx_data  = pix_lo;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_RST_LOW;
         wait_cnt     <= '0;
         idx          <= '0;
         pending      <= 1'b0;
         slp_wait     <= 1'b0;
         pix_stage    <= PIX_NONE;
         pix_cnt      <= '0;
         pix_lo       <= '0;
         x0_q         <= '0;
         y0_q         <= '0;
         x1_q         <= '0;
         y1_q         <= '0;
         win_err_q    <= 1'b0;
         frame_done_q <= 1'b0;
         init_done_q  <= 1'b0;
         cs_n_q       <= 1'b1;
         rst_out_q    <= 1'b0;
         frame_seen   <= 1'b0;
      end else begin
         win_err_q    <= 1'b0;
         frame_done_q <= 1'b0;

         // A byte is in flight from the start request until its tx_done.
         if (tx_start) begin
            pending <= 1'b1;
         end else if (tx_done) begin
            pending <= 1'b0;
         end

         case (state)
            ST_RST_LOW: begin
               if (wait_cnt == RST_LAST) begin
                  rst_out_q <= 1'b1;
                  wait_cnt  <= '0;
                  state     <= ST_RST_WAIT;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            ST_RST_WAIT: begin
               if (wait_cnt == RST_LAST) begin
                  wait_cnt <= '0;
                  idx      <= '0;
                  cs_n_q   <= 1'b0;
                  state    <= ST_INIT;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            ST_INIT: begin
               if (slp_wait) begin
                  if (wait_cnt == SLP_LAST) begin
                     slp_wait <= 1'b0;
                     wait_cnt <= '0;
                  end else begin
                     wait_cnt <= wait_cnt + 1'b1;
                  end
               end
               if (tx_done) begin
                  if (idx == 4'(INIT_DEPTH - 1)) begin
                     cs_n_q      <= 1'b1;
                     init_done_q <= 1'b1;
                     state       <= ST_IDLE;
                  end else begin
                     idx <= idx + 1'b1;
                     if (idx == 4'd0) begin
                        slp_wait <= 1'b1;
                        wait_cnt <= '0;
                     end
                  end
               end
            end
            ST_IDLE: begin
               if (win_valid) begin
                  if (win_bad) begin
                     win_err_q <= 1'b1;
                  end else begin
                     x0_q    <= win_x0;
                     y0_q    <= win_y0;
                     x1_q    <= win_x1;
                     y1_q    <= win_y1;
                     pix_cnt <= win_pixels;
                     idx     <= '0;
                     cs_n_q  <= 1'b0;
                     state   <= ST_WIN;
                  end
               end
            end
            ST_WIN: begin
               if (tx_done) begin
                  if (idx == 4'(WIN_DEPTH - 1)) begin
                     pix_stage <= PIX_NONE;
                     state     <= ST_STREAM;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            ST_STREAM: begin
               if (pix_fire) begin
                  pix_lo    <= pix_data[7:0];
                  pix_cnt   <= pix_cnt - 1'b1;
                  pix_stage <= PIX_HI;
               end
               if (tx_done) begin
                  if (pix_stage == PIX_HI) begin
                     pix_stage <= PIX_LO;
                  end else begin
                     pix_stage <= PIX_NONE;
                     if (pix_cnt == 16'd0) begin
                        frame_done_q <= 1'b1;
                        frame_seen   <= 1'b1;
                        cs_n_q       <= 1'b1;
                        state        <= ST_IDLE;
                     end
                  end
               end
            end
            default: state <= ST_RST_LOW;
         endcase
      end
   end

   spi_byte_tx #(
      .CLK_DIV (CLK_DIV)
   ) u_tx (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (tx_start),
      .dc      (tx_dc),
      .data    (tx_data),
      .busy    (tx_busy),
      .tx_done (tx_done),
      .scl     (lcd_clk_out),
      .sda     (lcd_data_out),
      .dc_line (lcd_dc_out)
   );

endmodule

// File: tb/tb_lcd_spi_ctrl.sv
// Directed bench for lcd_spi_ctrl: decodes the SPI pins into {dc, byte} entries and
// compares them with hand-written expected sequences.
module tb_lcd_spi_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        win_valid = 1'b0;
   logic        win_ready;
   logic [7:0]  win_x0 = '0, win_y0 = '0, win_x1 = '0, win_y1 = '0;
   logic        win_err;
   logic        pix_valid = 1'b0;
   logic        pix_ready;
   logic [15:0] pix_data = '0;
   logic        frame_done, init_done, busy;
   logic        bl_en = 1'b0;
   logic        lcd_rst_n_out, lcd_bl_out, lcd_cs_n_out, lcd_dc_out, lcd_clk_out, lcd_data_out;

   int n_checks = 0;
   int n_pass   = 0;

   lcd_spi_ctrl #(
      .LCD_W(132), .LCD_H(162), .CLK_DIV(1), .RST_CYCLES(10), .SLPOUT_CYCLES(20),
      .X_OFS(0), .Y_OFS(0)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .win_valid(win_valid), .win_ready(win_ready),
      .win_x0(win_x0), .win_y0(win_y0), .win_x1(win_x1), .win_y1(win_y1),
      .win_err(win_err),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
      .frame_done(frame_done), .init_done(init_done), .busy(busy), .bl_en(bl_en),
      .lcd_rst_n_out(lcd_rst_n_out), .lcd_bl_out(lcd_bl_out), .lcd_cs_n_out(lcd_cs_n_out),
      .lcd_dc_out(lcd_dc_out), .lcd_clk_out(lcd_clk_out), .lcd_data_out(lcd_data_out)
   );

   always #5 clk = ~clk;

   // SPI decoder and event counters
   logic [8:0] rx_q[$];
   int         rx_t[$];
   logic [8:0] exp_q[$];
   int         cyc = 0, nbits = 0, cs_bad = 0;
   logic [7:0] sh = '0;
   int         fd_cnt = 0, err_cnt = 0, scl_rises = 0, cs_falls = 0, cs_rises = 0;

   always @(posedge clk) begin
      cyc++;
      if (frame_done) fd_cnt++;
      if (win_err) err_cnt++;
   end

   always @(posedge lcd_clk_out or negedge rst_n) begin
      if (!rst_n) begin
         nbits = 0;
      end else begin
         if (lcd_cs_n_out) cs_bad++;
         sh = {sh[6:0], lcd_data_out};
         nbits++;
         if (nbits == 8) begin
            rx_q.push_back({lcd_dc_out, sh});
            rx_t.push_back(cyc);
            nbits = 0;
         end
      end
   end

   always @(posedge lcd_clk_out) scl_rises++;
   always @(negedge lcd_cs_n_out) cs_falls++;
   always @(posedge lcd_cs_n_out) cs_rises++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [11:0] out_vec();
      return {lcd_rst_n_out, lcd_bl_out, lcd_cs_n_out, lcd_dc_out, lcd_clk_out, lcd_data_out,
              win_ready, pix_ready, win_err, frame_done, init_done, busy};
   endfunction

   task automatic check_rx(input string tag);
      check({tag, "_len"}, rx_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
         check($sformatf("%s_b%0d", tag, i), rx_q[i], exp_q[i]);
   endtask

   task automatic release_and_init(input string tag);
      int n = 0;
      @(negedge clk);
      rst_n = 1'b1;
      while (!lcd_rst_n_out && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_rst_low_cycles"}, n, 10);
      n = 0;
      while (!init_done && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_init_in_time"}, init_done, 1'b1);
      check({tag, "_init_len"}, rx_q.size(), 6);
      if (rx_q.size() == 6) begin
         check({tag, "_slpout"}, rx_q[0], 9'h011);
         check({tag, "_slp_gap"}, (rx_t[1] - rx_t[0]) >= 38, 1'b1);
         check({tag, "_colmod"}, {rx_q[3], rx_q[4], rx_q[5]}, {9'h03A, 9'h105, 9'h029});
      end
      check({tag, "_idle_pins"}, {lcd_cs_n_out, busy, win_ready}, 3'b101);
   endtask

   task automatic send_win(input logic [7:0] x0, y0, x1, y1);
      int n = 0;
      @(negedge clk);
      win_valid = 1'b1;
      {win_x0, win_y0, win_x1, win_y1} = {x0, y0, x1, y1};
      while (!win_ready && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check("win_handshake_in_time", win_ready, 1'b1);
      @(posedge clk); #1;
      win_valid = 1'b0;
   endtask

   task automatic send_pix(input logic [15:0] d);
      int n = 0;
      @(negedge clk);
      pix_valid = 1'b1;
      pix_data  = d;
      while (!pix_ready && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check("pix_handshake_in_time", pix_ready, 1'b1);
      @(posedge clk); #1;
      pix_valid = 1'b0;
   endtask

   task automatic wait_fd(input int target, input string tag);
      int n = 0;
      while (fd_cnt < target && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_frame_done_count"}, fd_cnt, target);
   endtask

   initial begin
      int base_scl, base_cs, base_err, base_rise, fd_at_hs, n;

      #23;
      check("reset_outputs", out_vec(), 12'b001000000001);
      release_and_init("pwrup");
      bl_en = 1'b1;
      @(negedge clk);
      check("bl_before_frame", lcd_bl_out, 1'b0);

      // Rejected windows: x0 > x1, then x1 == LCD_W
      rx_q.delete();
      base_scl = scl_rises; base_cs = cs_falls; base_err = err_cnt;
      send_win(8'd5, 8'd0, 8'd3, 8'd0);
      repeat (3) @(negedge clk);
      check("err_pulse_1", err_cnt - base_err, 1);
      send_win(8'd0, 8'd0, 8'd132, 8'd0);
      repeat (3) @(negedge clk);
      check("err_pulse_2", err_cnt - base_err, 2);
      check("err_no_spi", {scl_rises - base_scl, cs_falls - base_cs}, 0);
      check("err_still_idle", {busy, win_ready}, 2'b01);

      // Window (1,0)-(2,1), four pixels
      rx_q.delete();
      base_rise = cs_rises; cs_bad = 0;
      send_win(8'd1, 8'd0, 8'd2, 8'd1);
      send_pix(16'hF800);
      send_pix(16'h07E0);
      send_pix(16'h001F);
      send_pix(16'hFFFF);
      wait_fd(1, "win1");
      exp_q = '{9'h02A, 9'h100, 9'h101, 9'h100, 9'h102, 9'h02B, 9'h100, 9'h100, 9'h100, 9'h101,
                9'h02C, 9'h1F8, 9'h100, 9'h107, 9'h1E0, 9'h100, 9'h11F, 9'h1FF, 9'h1FF};
      check_rx("win1");
      check("win1_cs_low_throughout", {cs_bad, cs_rises - base_rise}, {32'd0, 32'd1});
      repeat (3) @(negedge clk);
      check("win1_single_frame_done", fd_cnt, 1);
      check("bl_after_frame", lcd_bl_out, 1'b1);

      // Stall of 40 cycles between the two pixels of (0,0)-(1,0)
      rx_q.delete();
      send_win(8'd0, 8'd0, 8'd1, 8'd0);
      send_pix(16'h1234);
      n = 0;
      while (!pix_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      base_scl = scl_rises;
      repeat (40) @(negedge clk);
      check("stall_scl_static", {scl_rises - base_scl, 31'd0, lcd_clk_out}, 0);
      check("stall_cs_low", lcd_cs_n_out, 1'b0);
      send_pix(16'hABCD);
      wait_fd(2, "stall");
      exp_q = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h101, 9'h02B, 9'h100, 9'h100, 9'h100, 9'h100,
                9'h02C, 9'h112, 9'h134, 9'h1AB, 9'h1CD};
      check_rx("stall");

      // Back-to-back windows: second handshake must follow the first frame_done
      rx_q.delete();
      fork
         begin
            send_win(8'd3, 8'd4, 8'd3, 8'd4);
            send_win(8'd0, 8'd1, 8'd0, 8'd1);
            fd_at_hs = fd_cnt;
         end
         begin
            send_pix(16'h5555);
            send_pix(16'hAAAA);
         end
      join
      check("b2b_ready_after_done", fd_at_hs, 3);
      wait_fd(4, "b2b");
      check("b2b_len", rx_q.size(), 26);
      if (rx_q.size() == 26)
         check("b2b_tail", {rx_q[2], rx_q[11], rx_q[12], rx_q[24], rx_q[25]},
               {9'h103, 9'h155, 9'h155, 9'h1AA, 9'h1AA});

      // Reset in the middle of a pixel
      send_win(8'd0, 8'd0, 8'd0, 8'd0);
      send_pix(16'hC3C3);
      base_scl = scl_rises;
      n = 0;
      while (scl_rises - base_scl < 3 && n < 500) begin
         @(negedge clk);
         n++;
      end
      #1 rst_n = 1'b0;
      #1 check("midstream_reset_outputs", out_vec(), 12'b001000000001);
      check("midstream_no_frame", fd_cnt, 4);
      rx_q.delete();
      rx_t.delete();
      repeat (2) @(negedge clk);
      release_and_init("rerun");
      check("bl_cleared_by_reset", lcd_bl_out, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
